// File: rtl/arc4_key_cracker.sv
// Brute-force ARC4 key search over 24-bit keys, stopping at the first key whose plaintext is all printable ASCII.
// Optional macro ARC4_CRACK_EARLY_ABORT_EN rejects a key at its first non-printable byte instead of after the full scan.
module arc4_key_cracker #(
  parameter logic [23:0] KEY_LO = 24'h000000,
  parameter logic [23:0] KEY_HI = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        rdy,
  output logic [23:0] key,
  output logic        key_valid,
  output logic [7:0]  ct_addr,
  input  logic [7:0]  ct_rddata,
  output logic [23:0] key_attempt,
  input  logic [7:0]  pt_addr_final,
  output logic [7:0]  pt_rddata_final,
  output logic [3:0]  fsm_state
);

  // Handshake: a start is taken on any rising edge where en=1 and rdy=1; rdy drops on that
  // same edge and rises again on the edge that stores the result. en is ignored while rdy=0.

  typedef enum logic [3:0] {
    IDLE, INIT, KSA, LEN_WAIT, LEN_LATCH, PRGA_STEP, PRGA_WAIT, PRGA_XOR, CHECK, NEXT, DONE
  } state_t;

  state_t      state;
  logic [7:0]  s_mem  [256];
  logic [7:0]  pt_mem [256];
  logic [7:0]  i, j, n, len;
  logic [1:0]  kidx;

  logic [7:0]  kbyte, i_inc, j_ksa, j_prga;
  logic [7:0]  swap_a, swap_b, va, vb;
  logic [7:0]  pad_idx, pad, pt_byte;
  logic        byte_ok, pt_ok;

  function automatic logic is_print(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

  assign fsm_state       = state;
  assign pt_rddata_final = pt_mem[pt_addr_final];

  always_comb begin
    case (kidx)
      2'd0:    kbyte = key_attempt[23:16];
      2'd1:    kbyte = key_attempt[15:8];
      default: kbyte = key_attempt[7:0];
    endcase
  end

  // One shared swap port: KSA swaps S[i],S[j'] and PRGA swaps S[i+1],S[j'] in the same cycle slot.
  always_comb begin
    i_inc   = i + 8'd1;
    j_ksa   = j + s_mem[i] + kbyte;
    j_prga  = j + s_mem[i_inc];
    swap_a  = (state == KSA) ? i : i_inc;
    swap_b  = (state == KSA) ? j_ksa : j_prga;
    va      = s_mem[swap_a];
    vb      = s_mem[swap_b];
    pad_idx = s_mem[i] + s_mem[j];
    pad     = s_mem[pad_idx];
    pt_byte = pad ^ ct_rddata;
    byte_ok = is_print(pt_byte);
  end

  always_comb begin
    pt_ok = 1'b1;
    for (int x = 1; x < 256; x++) begin
      if ((x <= int'(len)) && !is_print(pt_mem[x])) pt_ok = 1'b0;
    end
  end

  // Data arrays carry no reset: S is rebuilt in INIT for every key and pt is only meaningful after a search.
  always_ff @(posedge clk) begin
    case (state)
      INIT: begin
        for (int x = 0; x < 256; x++) s_mem[x] <= 8'(x);
      end
      KSA, PRGA_STEP: begin
        s_mem[swap_a] <= vb;
        s_mem[swap_b] <= va;
      end
      LEN_LATCH: pt_mem[0] <= ct_rddata;
      PRGA_XOR:  pt_mem[n] <= pt_byte;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rdy         <= 1'b1;
      key_valid   <= 1'b0;
      key         <= 24'h0;
      key_attempt <= KEY_LO;
      ct_addr     <= 8'h0;
      i           <= 8'h0;
      j           <= 8'h0;
      n           <= 8'h0;
      len         <= 8'h0;
      kidx        <= 2'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (en) begin
            rdy         <= 1'b0;
            key_valid   <= 1'b0;
            key         <= 24'h0;
            key_attempt <= KEY_LO;
            state       <= INIT;
          end
        end
        INIT: begin
          i     <= 8'h0;
          j     <= 8'h0;
          kidx  <= 2'd0;
          state <= KSA;
        end
        KSA: begin
          j    <= j_ksa;
          i    <= i_inc;
          kidx <= (kidx == 2'd2) ? 2'd0 : kidx + 2'd1;
          if (i == 8'hFF) begin
            ct_addr <= 8'h0;
            state   <= LEN_WAIT;
          end
        end
        LEN_WAIT: state <= LEN_LATCH;
        LEN_LATCH: begin
          len   <= ct_rddata;
          i     <= 8'h0;
          j     <= 8'h0;
          n     <= 8'h1;
          state <= (ct_rddata == 8'h0) ? CHECK : PRGA_STEP;
        end
        PRGA_STEP: begin
          i       <= i_inc;
          j       <= j_prga;
          ct_addr <= n;
          state   <= PRGA_WAIT;
        end
        PRGA_WAIT: state <= PRGA_XOR;
        PRGA_XOR: begin
          n <= n + 8'd1;
`ifdef ARC4_CRACK_EARLY_ABORT_EN
          if (!byte_ok)        state <= NEXT;
          else if (n == len)   state <= CHECK;
          else                 state <= PRGA_STEP;
`else
          if (n == len) state <= CHECK;
          else          state <= PRGA_STEP;
`endif
        end
        CHECK: begin
          if (pt_ok) begin
            key       <= key_attempt;
            key_valid <= 1'b1;
            rdy       <= 1'b1;
            state     <= DONE;
          end else begin
            state <= NEXT;
          end
        end
        NEXT: begin
          // The search never wraps past KEY_HI.
          if (key_attempt == KEY_HI) begin
            key       <= 24'h0;
            key_valid <= 1'b0;
            rdy       <= 1'b1;
            state     <= DONE;
          end else begin
            key_attempt <= key_attempt + 24'd1;
            state       <= INIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Only consumed by the early-abort build.
  logic unused_ok;
  assign unused_ok = byte_ok;

endmodule

// File: tb/tb_arc4_key_cracker.sv
// Randomized bench for arc4_key_cracker: two instances (wide and narrow key ranges) checked against an ARC4 reference model.
module tb_arc4_key_cracker;

  localparam logic [23:0] LO_B = 24'h000005;
  localparam logic [23:0] HI_B = 24'h000014;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        en_a, en_b;
  logic        rdy_a, rdy_b, key_valid_a, key_valid_b;
  logic [23:0] key_a, key_b, key_attempt_a, key_attempt_b;
  logic [7:0]  ct_addr_a, ct_addr_b, ct_q_a, ct_q_b;
  logic [7:0]  pt_addr_a, pt_addr_b, pt_rd_a, pt_rd_b;
  logic [3:0]  fsm_a, fsm_b;

  logic [7:0]  ct_mem [256];
  logic [7:0]  msg    [256];
  logic [7:0]  ks     [256];
  logic [31:0] exp_q  [$];
  int n_vec = 0;
  int n_err = 0;

  arc4_key_cracker #(.KEY_LO(24'h000000), .KEY_HI(24'hFFFFFF)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .rdy(rdy_a), .key(key_a), .key_valid(key_valid_a),
    .ct_addr(ct_addr_a), .ct_rddata(ct_q_a), .key_attempt(key_attempt_a),
    .pt_addr_final(pt_addr_a), .pt_rddata_final(pt_rd_a), .fsm_state(fsm_a));

  arc4_key_cracker #(.KEY_LO(LO_B), .KEY_HI(HI_B)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .rdy(rdy_b), .key(key_b), .key_valid(key_valid_b),
    .ct_addr(ct_addr_b), .ct_rddata(ct_q_b), .key_attempt(key_attempt_b),
    .pt_addr_final(pt_addr_b), .pt_rddata_final(pt_rd_b), .fsm_state(fsm_b));

  // Synchronous-read ciphertext ROM, one read port per instance.
  always @(posedge clk) begin
    ct_q_a <= ct_mem[ct_addr_a];
    ct_q_b <= ct_mem[ct_addr_b];
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

  // Fills ks[1..len] with the ARC4 keystream for a 24-bit key.
  task automatic gen_ks(input logic [23:0] k, input int len);
    int s[256];
    int i, j, t;
    logic [7:0] kb;
    for (int x = 0; x < 256; x++) s[x] = x;
    j = 0;
    for (int x = 0; x < 256; x++) begin
      kb = 8'(k >> (8 * (2 - (x % 3))));
      j = (j + s[x] + int'(kb)) % 256;
      t = s[x]; s[x] = s[j]; s[j] = t;
    end
    i = 0; j = 0;
    for (int m = 1; m <= len; m++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      ks[m] = 8'(s[(s[i] + s[j]) % 256]);
    end
  endtask

  // Linear search; leaves ks holding the keystream of the last key tried.
  task automatic model_search(input logic [23:0] lo, input logic [23:0] hi,
                              output bit found, output logic [23:0] fk);
    int len;
    bit ok;
    logic [23:0] kk;
    len = int'(ct_mem[0]);
    found = 1'b0;
    fk = 24'h0;
    kk = lo;
    forever begin
      gen_ks(kk, len);
      ok = 1'b1;
      for (int m = 1; m <= len; m++) if (!printable(ct_mem[m] ^ ks[m])) ok = 1'b0;
      if (ok) begin
        found = 1'b1;
        fk = kk;
        return;
      end
      if (kk == hi) return;
      kk = kk + 24'd1;
    end
  endtask

  task automatic encrypt_msg(input logic [23:0] k, input int len);
    ct_mem[0] = 8'(len);
    gen_ks(k, len);
    for (int m = 1; m <= len; m++) ct_mem[m] = msg[m] ^ ks[m];
  endtask

  task automatic random_msg(input logic [23:0] k, input int len);
    for (int m = 1; m <= len; m++) msg[m] = 8'($urandom_range(32'h20, 32'h7E));
    encrypt_msg(k, len);
  endtask

  // ---------------- drivers ----------------
  task automatic pulse(input bit which);
    @(negedge clk);
    if (which) en_b = 1'b1; else en_a = 1'b1;
    @(negedge clk);
    en_a = 1'b0;
    en_b = 1'b0;
  endtask

  task automatic wait_rdy(input bit which, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if ((which ? rdy_b : rdy_a) === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
    check_eq("timeout", 32'd0, 32'd1);
  endtask

  // Full search on dut_a; poke_at>0 fires a stray en that many cycles into the search.
  task automatic run_a(input string tag, input int poke_at);
    bit found, ok;
    logic [23:0] fk;
    int len;
    len = int'(ct_mem[0]);
    model_search(24'h0, 24'hFFFFFF, found, fk);
    exp_q.delete();
    for (int m = 1; m <= len; m++) exp_q.push_back(32'(ct_mem[m] ^ ks[m]));
    pulse(1'b0);
    check_eq({tag, "_busy"}, 32'(rdy_a), 32'd0);
    check_eq({tag, "_kv_clr"}, 32'(key_valid_a), 32'd0);
    check_eq({tag, "_key_clr"}, 32'(key_a), 32'd0);
    if (poke_at > 0) begin
      repeat (poke_at) @(negedge clk);
      pulse(1'b0);
      check_eq({tag, "_poke_busy"}, 32'(rdy_a), 32'd0);
      check_eq({tag, "_poke_ignored"}, 32'(key_attempt_a >= 24'd2), 32'd1);
    end
    wait_rdy(1'b0, 20000, ok);
    if (ok) begin
      check_eq({tag, "_kv"}, 32'(key_valid_a), 32'(found));
      check_eq({tag, "_key"}, 32'(key_a), 32'(found ? fk : 24'h0));
      pt_addr_a = 8'd0;
      #1;
      check_eq({tag, "_pt0"}, 32'(pt_rd_a), 32'(len));
      for (int m = 1; m <= len; m++) begin
        pt_addr_a = 8'(m);
        #1;
        check_eq({tag, "_pt"}, 32'(pt_rd_a), exp_q.pop_front());
      end
    end
  endtask

  task automatic run_b(input string tag, input int budget);
    bit found, ok;
    logic [23:0] fk;
    model_search(LO_B, HI_B, found, fk);
    pulse(1'b1);
    check_eq({tag, "_busy"}, 32'(rdy_b), 32'd0);
    check_eq({tag, "_kv_clr"}, 32'(key_valid_b), 32'd0);
    wait_rdy(1'b1, budget, ok);
    if (ok) begin
      check_eq({tag, "_kv"}, 32'(key_valid_b), 32'(found));
      check_eq({tag, "_key"}, 32'(key_b), 32'(found ? fk : 24'h0));
      check_eq({tag, "_attempt"}, 32'(key_attempt_b), 32'(found ? fk : HI_B));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    string hello;
    bit found, ok;
    logic [23:0] fk;
    int tries;

    rst = 1'b1; en_a = 1'b0; en_b = 1'b0; pt_addr_a = 8'd0; pt_addr_b = 8'd0;
    for (int m = 0; m < 256; m++) ct_mem[m] = 8'h0;
    repeat (3) @(negedge clk);
    check_eq("rst_rdy", 32'(rdy_a), 32'd1);
    check_eq("rst_attempt_b", 32'(key_attempt_b), 32'(LO_B));
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("idle_rdy", 32'(rdy_a), 32'd1);
    check_eq("idle_kv", 32'(key_valid_a), 32'd0);
    check_eq("idle_key", 32'(key_a), 32'd0);
    check_eq("idle_attempt", 32'(key_attempt_a), 32'd0);
    check_eq("idle_ct_addr", 32'(ct_addr_a), 32'd0);

    // Known ASCII message under key 0x000018, with a stray en mid-search.
    hello = "Hello, ARC4!";
    for (int m = 0; m < hello.len(); m++) msg[m + 1] = hello[m];
    encrypt_msg(24'h000018, hello.len());
    run_a("hello", 700);

    for (int r = 0; r < 4; r++) begin
      random_msg(24'($urandom_range(0, 12)), $urandom_range(6, 20));
      run_a($sformatf("rand%0d", r), 0);
    end

    // Empty message passes on the first key, within one key's cycle budget.
    ct_mem[0] = 8'd0;
    run_b("len0", 600);

    // Ciphertext with no printable decryption in the narrow range.
    tries = 0;
    do begin
      ct_mem[0] = 8'd8;
      for (int m = 1; m <= 8; m++) ct_mem[m] = 8'($urandom_range(0, 255));
      model_search(LO_B, HI_B, found, fk);
      tries++;
    end while (found && tries < 10);
    run_b("nosol", 12000);

    // Asynchronous reset in the middle of PRGA.
    random_msg(24'd10, 16);
    pulse(1'b0);
    ok = 1'b0;
    for (int c = 0; c < 5000 && !ok; c++) begin
      @(negedge clk);
      if (key_attempt_a == 24'd3 && ct_addr_a != 8'd0) ok = 1'b1;
    end
    check_eq("reach_prga", 32'(ok), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_rdy", 32'(rdy_a), 32'd1);
    check_eq("arst_kv", 32'(key_valid_a), 32'd0);
    check_eq("arst_attempt", 32'(key_attempt_a), 32'd0);
    check_eq("arst_ct_addr", 32'(ct_addr_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    random_msg(24'($urandom_range(0, 8)), $urandom_range(4, 16));
    run_a("post_rst", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
